// File: rtl/dispatch_queue_if.sv
// -----------------------------------------------------------------------------
// dispatch_queue_if
// Bundles the decoder-side enqueue handshake, the flush strobe, the head
// payload, the three functional-unit dispatch handshakes and the status
// outputs of dispatch_queue.
//   master : decoder / reservation-station side (drives in_*, flush, *_ready)
//   slave  : dispatch_queue side (drives in_ready, out_*, *_valid, illegal*,
//            count)
// -----------------------------------------------------------------------------
interface dispatch_queue_if #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 5
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_pc;
   logic [31:0]       in_inst;
   logic [2:0]        in_fu_type;
   logic              in_reg_write;
   logic [3:0]        in_imm_sel;
   logic [1:0]        in_opa_sel;
   logic [1:0]        in_opb_sel;
   logic [3:0]        in_alu_ctrl;
   logic [3:0]        in_mem_ctrl;
   logic [3:0]        in_br_ctrl;
   logic [87:0]       out_uop;
   logic [TAG_W-1:0]  out_tag;
   logic              alu_valid;
   logic              alu_ready;
   logic              lsq_valid;
   logic              lsq_ready;
   logic              bra_valid;
   logic              bra_ready;
   logic              illegal;
   logic [31:0]       illegal_pc;
   logic [CNT_W-1:0]  count;

   modport master (
      output flush, in_valid, in_pc, in_inst, in_fu_type, in_reg_write,
             in_imm_sel, in_opa_sel, in_opb_sel, in_alu_ctrl, in_mem_ctrl,
             in_br_ctrl, alu_ready, lsq_ready, bra_ready,
      input  in_ready, out_uop, out_tag, alu_valid, lsq_valid, bra_valid,
             illegal, illegal_pc, count
   );

   modport slave (
      input  flush, in_valid, in_pc, in_inst, in_fu_type, in_reg_write,
             in_imm_sel, in_opa_sel, in_opb_sel, in_alu_ctrl, in_mem_ctrl,
             in_br_ctrl, alu_ready, lsq_ready, bra_ready,
      output in_ready, out_uop, out_tag, alu_valid, lsq_valid, bra_valid,
             illegal, illegal_pc, count
   );
endinterface

// File: rtl/dispatch_queue.sv
// -----------------------------------------------------------------------------
// dispatch_queue
// In-order circular buffer of decoded micro-ops between the decoder and the
// ALU / LSQ / branch reservation stations. The oldest entry is steered to the
// port named by its FU type; a stalled head blocks everything behind it.
// Each dispatch consumes one value of a wrapping sequence tag. Micro-ops with
// no legal FU type are dropped and reported with a one-cycle illegal pulse.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset (also zeroes the tag counter)
//   bus   : dispatch_queue_if.slave (enqueue side, flush, head payload and
//           tag, FU handshakes, illegal report, occupancy)
// -----------------------------------------------------------------------------
module dispatch_queue #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   dispatch_queue_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int UOP_W = 88;

   localparam logic [2:0]       FU_ALU   = 3'b001;
   localparam logic [2:0]       FU_LSQ   = 3'b010;
   localparam logic [2:0]       FU_BRA   = 3'b100;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [TAG_W-1:0] TAG_ONE  = TAG_W'(1);

   // Only one-hot FU selects name a real reservation station.
   function automatic logic fu_legal(input logic [2:0] fu);
      case (fu)
         FU_ALU, FU_LSQ, FU_BRA: return 1'b1;
         default:                return 1'b0;
      endcase
   endfunction

   logic [UOP_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic             illegal_q, illegal_d;
   logic [31:0]      illegal_pc_q, illegal_pc_d;

   logic             in_ready_s;
   logic             empty_s;
   logic [UOP_W-1:0] in_uop_s;
   logic [UOP_W-1:0] head_uop_s;
   logic [2:0]       head_fu_s;
   logic             alu_valid_s, lsq_valid_s, bra_valid_s;
   logic             enq_fire_s, disp_fire_s;

   // Handshake decode, head steering and next-state computation.
   always_comb begin
      in_ready_s   = (count_q != FULL_CNT);
      empty_s      = (count_q == {CNT_W{1'b0}});
      in_uop_s     = {bus.in_pc, bus.in_inst, bus.in_fu_type, bus.in_reg_write,
                      bus.in_imm_sel, bus.in_opa_sel, bus.in_opb_sel,
                      bus.in_alu_ctrl, bus.in_mem_ctrl, bus.in_br_ctrl};
      head_uop_s   = mem_q[head_q];
      head_fu_s    = head_uop_s[23:21];
      alu_valid_s  = 1'b0;
      lsq_valid_s  = 1'b0;
      bra_valid_s  = 1'b0;
      head_d       = head_q;
      tail_d       = tail_q;
      count_d      = count_q;
      tag_d        = tag_q;
      illegal_pc_d = illegal_pc_q;

      // Stored entries are always legal, so exactly one port is selected.
      if (!empty_s) begin
         case (head_fu_s)
            FU_ALU:  alu_valid_s = 1'b1;
            FU_LSQ:  lsq_valid_s = 1'b1;
            FU_BRA:  bra_valid_s = 1'b1;
            default: alu_valid_s = 1'b0;
         endcase
      end else begin
         alu_valid_s = 1'b0;
      end

      // Flush suppresses both handshakes and the illegal report.
      enq_fire_s  = bus.in_valid & in_ready_s & fu_legal(bus.in_fu_type) & ~bus.flush;
      illegal_d   = bus.in_valid & in_ready_s & ~fu_legal(bus.in_fu_type) & ~bus.flush;
      disp_fire_s = ((alu_valid_s & bus.alu_ready) |
                     (lsq_valid_s & bus.lsq_ready) |
                     (bra_valid_s & bus.bra_ready)) & ~bus.flush;

      if (bus.flush) begin
         head_d  = {PTR_W{1'b0}};
         tail_d  = {PTR_W{1'b0}};
         count_d = {CNT_W{1'b0}};
      end else begin
         if (enq_fire_s) begin
            tail_d = tail_q + PTR_ONE;
         end else begin
            tail_d = tail_q;
         end
         if (disp_fire_s) begin
            head_d = head_q + PTR_ONE;
            tag_d  = tag_q + TAG_ONE;
         end else begin
            head_d = head_q;
         end
         case ({enq_fire_s, disp_fire_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end

      if (illegal_d) begin
         illegal_pc_d = bus.in_pc;
      end else begin
         illegal_pc_d = illegal_pc_q;
      end
   end

   // Control state registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_q       <= {PTR_W{1'b0}};
         tail_q       <= {PTR_W{1'b0}};
         count_q      <= {CNT_W{1'b0}};
         tag_q        <= {TAG_W{1'b0}};
         illegal_q    <= 1'b0;
         illegal_pc_q <= 32'h0000_0000;
      end else begin
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         tag_q        <= tag_d;
         illegal_q    <= illegal_d;
         illegal_pc_q <= illegal_pc_d;
      end
   end

   // Payload storage; contents are only observed through the occupied range.
   always_ff @(posedge clk) begin
      if (rst_n && enq_fire_s) begin
         mem_q[tail_q] <= in_uop_s;
      end
   end

   assign bus.in_ready   = in_ready_s;
   assign bus.out_uop    = empty_s ? {UOP_W{1'b0}} : head_uop_s;
   assign bus.out_tag    = tag_q;
   assign bus.alu_valid  = alu_valid_s;
   assign bus.lsq_valid  = lsq_valid_s;
   assign bus.bra_valid  = bra_valid_s;
   assign bus.illegal    = illegal_q;
   assign bus.illegal_pc = illegal_pc_q;
   assign bus.count      = count_q;
endmodule

// File: tb/tb_dispatch_queue.sv
// -----------------------------------------------------------------------------
// tb_dispatch_queue
// Directed scenarios followed by randomized traffic. A stimulus process drives
// the bus on the falling edge; a monitor process samples shortly afterwards,
// compares the DUT against a queue-based reference model, then advances the
// model by what the coming rising edge must do.
// -----------------------------------------------------------------------------
module tb_dispatch_queue;
   localparam int DEPTH = 4;
   localparam int TAG_W = 5;

   logic clk;
   logic rst_n;

   dispatch_queue_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

   dispatch_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [87:0]      mq [$];
   logic [TAG_W-1:0] m_tag    = '0;
   logic             m_ill    = 1'b0;
   logic [31:0]      m_ill_pc = 32'h0;
   logic             rst_flag = 1'b1;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [87:0] act, input logic [87:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic legal(input logic [2:0] fu);
      return (fu == 3'b001) || (fu == 3'b010) || (fu == 3'b100);
   endfunction

   // Monitor + reference model
   initial begin
      int          n;
      logic [2:0]  hfu;
      logic        disp;
      logic        enq;
      logic [87:0] in_uop;
      @(posedge clk);
      forever begin
         @(negedge clk);
         #2;
         n   = mq.size();
         hfu = (n != 0) ? mq[0][23:21] : 3'b000;
         chk("in_ready",  88'(bus.in_ready),  88'(n != DEPTH));
         chk("count",     88'(bus.count),     88'(n));
         chk("alu_valid", 88'(bus.alu_valid), 88'(n != 0 && hfu == 3'b001));
         chk("lsq_valid", 88'(bus.lsq_valid), 88'(n != 0 && hfu == 3'b010));
         chk("bra_valid", 88'(bus.bra_valid), 88'(n != 0 && hfu == 3'b100));
         chk("illegal",   88'(bus.illegal),   88'(m_ill));
         if (n != 0) begin
            chk("out_uop", bus.out_uop, mq[0]);
            chk("out_tag", 88'(bus.out_tag), 88'(m_tag));
         end
         if (m_ill) chk("illegal_pc", 88'(bus.illegal_pc), 88'(m_ill_pc));
         if (rst_flag) begin
            chk("rst_illegal_pc", 88'(bus.illegal_pc), 88'(0));
            chk("rst_out_uop",    bus.out_uop,         88'(0));
            chk("rst_out_tag",    88'(bus.out_tag),    88'(0));
         end

         // Advance the model by the upcoming rising edge
         rst_flag = !rst_n;
         in_uop = {bus.in_pc, bus.in_inst, bus.in_fu_type, bus.in_reg_write,
                   bus.in_imm_sel, bus.in_opa_sel, bus.in_opb_sel,
                   bus.in_alu_ctrl, bus.in_mem_ctrl, bus.in_br_ctrl};
         if (!rst_n) begin
            mq.delete();
            m_tag    = '0;
            m_ill    = 1'b0;
            m_ill_pc = 32'h0;
         end else if (bus.flush) begin
            mq.delete();
            m_ill = 1'b0;
         end else begin
            disp = (n != 0) && ((hfu == 3'b001 && bus.alu_ready) ||
                                (hfu == 3'b010 && bus.lsq_ready) ||
                                (hfu == 3'b100 && bus.bra_ready));
            enq   = bus.in_valid && (n != DEPTH) && legal(bus.in_fu_type);
            m_ill = bus.in_valid && (n != DEPTH) && !legal(bus.in_fu_type);
            if (m_ill) m_ill_pc = bus.in_pc;
            if (disp) begin
               void'(mq.pop_front());
               m_tag = m_tag + 1'b1;
            end
            if (enq) mq.push_back(in_uop);
         end
      end
   end

   task automatic drv(input logic v, input logic [31:0] pc, input logic [2:0] fu,
                      input logic ar, input logic lr, input logic br,
                      input logic fl, input logic rs);
      @(negedge clk);
      rst_n              = rs;
      bus.flush          = fl;
      bus.in_valid       = v;
      bus.in_pc          = pc;
      bus.in_fu_type     = fu;
      bus.in_inst        = $urandom;
      bus.in_reg_write   = 1'($urandom);
      bus.in_imm_sel     = 4'($urandom);
      bus.in_opa_sel     = 2'($urandom);
      bus.in_opb_sel     = 2'($urandom);
      bus.in_alu_ctrl    = 4'($urandom);
      bus.in_mem_ctrl    = 4'($urandom);
      bus.in_br_ctrl     = 4'($urandom);
      bus.alu_ready      = ar;
      bus.lsq_ready      = lr;
      bus.bra_ready      = br;
   endtask

   // Stimulus
   initial begin
      logic [2:0] fu;
      rst_n            = 1'b0;
      bus.flush        = 1'b0;
      bus.in_valid     = 1'b0;
      bus.in_pc        = 32'h0;
      bus.in_inst      = 32'h0;
      bus.in_fu_type   = 3'b000;
      bus.in_reg_write = 1'b0;
      bus.in_imm_sel   = 4'h0;
      bus.in_opa_sel   = 2'b00;
      bus.in_opb_sel   = 2'b00;
      bus.in_alu_ctrl  = 4'h0;
      bus.in_mem_ctrl  = 4'h0;
      bus.in_br_ctrl   = 4'h0;
      bus.alu_ready    = 1'b0;
      bus.lsq_ready    = 1'b0;
      bus.bra_ready    = 1'b0;

      // Reset held across two rising edges
      drv(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Single ALU op
      drv(1'b1, 32'h100, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      repeat (3) drv(1'b0, 32'h0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

      // Head-of-line block: LSQ stalled ahead of a ready ALU op
      drv(1'b1, 32'h200, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      drv(1'b1, 32'h204, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      repeat (5) drv(1'b0, 32'h0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      repeat (3) drv(1'b0, 32'h0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

      // Fill to full with a branch at the head, then dispatch while a 5th waits
      drv(1'b1, 32'h400, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      drv(1'b1, 32'h404, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      drv(1'b1, 32'h408, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      drv(1'b1, 32'h40c, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      repeat (2) drv(1'b1, 32'h410, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      drv(1'b1, 32'h410, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      repeat (6) drv(1'b0, 32'h0, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);

      // Illegal FU types
      drv(1'b1, 32'h300, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      drv(1'b0, 32'h0,   3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      drv(1'b1, 32'h304, 3'b011, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      repeat (2) drv(1'b0, 32'h0, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);

      // Flush with three queued entries and a concurrent enqueue/dispatch
      drv(1'b1, 32'h500, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      drv(1'b1, 32'h504, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      drv(1'b1, 32'h508, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      drv(1'b1, 32'h50c, 3'b001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      repeat (2) drv(1'b0, 32'h0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

      // Back-to-back ALU traffic to wrap the tag
      repeat (40) drv(1'b1, $urandom, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

      // Randomized traffic with occasional flush, illegal ops and one reset
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(99) < 85) begin
            case ($urandom_range(2))
               0:       fu = 3'b001;
               1:       fu = 3'b010;
               default: fu = 3'b100;
            endcase
         end else begin
            fu = 3'($urandom);
         end
         drv($urandom_range(99) < 70, $urandom, fu,
             $urandom_range(99) < 60, $urandom_range(99) < 60,
             $urandom_range(99) < 60, $urandom_range(99) < 3,
             !(i >= 1500 && i < 1502));
      end

      repeat (8) drv(1'b0, 32'h0, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      #4;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
